// File: rtl/ddr_rx_pkg.sv
// ddr_rx_pkg: shared definitions for the HDR-DDR target receiver and the
// target CCC engine.
//   - reception mode codes and their field lengths (in SDA bits)
//   - receive FSM state encoding
//   - HDR-DDR parity over a 16-bit history
package ddr_rx_pkg;

  localparam logic [4:0] MODE_PREAMBLE     = 5'd0;
  localparam logic [4:0] MODE_CMD_WORD     = 5'd1;
  localparam logic [4:0] MODE_DESER_BYTE   = 5'd2;
  localparam logic [4:0] MODE_CHECK_PARITY = 5'd3;
  localparam logic [4:0] MODE_DATA_WORD    = 5'd4;

  localparam logic [4:0] LEN_PREAMBLE     = 5'd2;
  localparam logic [4:0] LEN_CMD_WORD     = 5'd16;
  localparam logic [4:0] LEN_DESER_BYTE   = 5'd8;
  localparam logic [4:0] LEN_CHECK_PARITY = 5'd2;
  localparam logic [4:0] LEN_DATA_WORD    = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } rx_state_e;

  function automatic logic mode_legal(input logic [4:0] mode);
    return (mode <= MODE_DATA_WORD);
  endfunction

  function automatic logic [4:0] mode_len(input logic [4:0] mode);
    logic [4:0] len;
    case (mode)
      MODE_PREAMBLE:     len = LEN_PREAMBLE;
      MODE_CMD_WORD:     len = LEN_CMD_WORD;
      MODE_DESER_BYTE:   len = LEN_DESER_BYTE;
      MODE_CHECK_PARITY: len = LEN_CHECK_PARITY;
      MODE_DATA_WORD:    len = LEN_DATA_WORD;
      default:           len = 5'd0;
    endcase
    return len;
  endfunction

  // Modes whose data bits feed the parity history.
  function automatic logic mode_has_parity(input logic [4:0] mode);
    return (mode == MODE_CMD_WORD) || (mode == MODE_DESER_BYTE) ||
           (mode == MODE_DATA_WORD);
  endfunction

  // {PA1, PA0}: PA1 over odd bits, PA0 over even bits inverted.
  function automatic logic [1:0] ddr_parity(input logic [15:0] h);
    logic pa1;
    logic pa0;
    pa1 = 1'b0;
    pa0 = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      pa1 = pa1 ^ h[2*i+1];
      pa0 = pa0 ^ h[2*i];
    end
    return {pa1, pa0};
  endfunction

endpackage

// File: rtl/ddr_rx_target_if.sv
// ddr_rx_target_if: request/result bundle between the target CCC engine
// (master) and the HDR-DDR bit receiver (slave).
//   i_rx_en / i_rx_mode      : start request and mode (engine -> receiver)
//   o_rx_mode_done           : one-cycle field-complete pulse
//   o_preamble, o_rnw, o_ccc_value, o_rx_byte, o_rx_word : captured fields
//   o_rx_error               : parity mismatch / illegal mode
//   o_restart_done, o_exit_done : HDR Restart / Exit pulses
//   o_busy                   : receiver is collecting bits
interface ddr_rx_target_if;
  logic        i_rx_en;
  logic [4:0]  i_rx_mode;
  logic        o_rx_mode_done;
  logic [1:0]  o_preamble;
  logic        o_rnw;
  logic [7:0]  o_ccc_value;
  logic [7:0]  o_rx_byte;
  logic [15:0] o_rx_word;
  logic        o_rx_error;
  logic        o_restart_done;
  logic        o_exit_done;
  logic        o_busy;

  modport master (
    output i_rx_en, i_rx_mode,
    input  o_rx_mode_done, o_preamble, o_rnw, o_ccc_value, o_rx_byte,
           o_rx_word, o_rx_error, o_restart_done, o_exit_done, o_busy
  );

  modport slave (
    input  i_rx_en, i_rx_mode,
    output o_rx_mode_done, o_preamble, o_rnw, o_ccc_value, o_rx_byte,
           o_rx_word, o_rx_error, o_restart_done, o_exit_done, o_busy
  );
endinterface

// File: rtl/hdr_pattern_detector.sv
// hdr_pattern_detector: HDR Restart / Exit recognition.
// Counts SDA falling edges while SCL is low; the count clears on every SCL
// rise.
//   i_sys_clk, i_sys_rst : clock, synchronous active-low reset
//   i_scl, i_sda         : synchronized bus lines
//   o_abort              : count >= 2, kill any reception in progress
//   o_restart_done       : pulse, SCL rose with a count of 2 or 3
//   o_exit_done          : pulse, count reached 4
module hdr_pattern_detector (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_abort,
  output logic o_restart_done,
  output logic o_exit_done
);

  logic       scl_q;
  logic       sda_q;
  logic [2:0] fall_cnt_q;
  logic       restart_q;
  logic       exit_q;
  logic       scl_rise;
  logic       sda_fall;

  always_comb begin
    scl_rise = i_scl & ~scl_q;
    sda_fall = sda_q & ~i_sda & ~i_scl;
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      scl_q      <= 1'b0;
      sda_q      <= 1'b0;
      fall_cnt_q <= '0;
      restart_q  <= 1'b0;
      exit_q     <= 1'b0;
    end else begin
      scl_q     <= i_scl;
      sda_q     <= i_sda;
      restart_q <= 1'b0;
      exit_q    <= 1'b0;
      if (scl_rise) begin
        fall_cnt_q <= '0;
        if ((fall_cnt_q == 3'd2) || (fall_cnt_q == 3'd3)) restart_q <= 1'b1;
      end else if (sda_fall && (fall_cnt_q != 3'd4)) begin
        // Saturate at 4 so a long Exit pattern pulses only once.
        fall_cnt_q <= fall_cnt_q + 3'd1;
        if (fall_cnt_q == 3'd3) exit_q <= 1'b1;
      end
    end
  end

  assign o_abort        = (fall_cnt_q >= 3'd2);
  assign o_restart_done = restart_q;
  assign o_exit_done    = exit_q;

endmodule

// File: rtl/ddr_rx_target.sv
// ddr_rx_target: target-side HDR-DDR bit receiver.
// Samples SDA on both SCL edges and assembles the field selected by the CCC
// engine (preamble, command word, byte, parity, data word). Returns a
// one-cycle done pulse with the captured field and flags parity errors.
// HDR Restart / Exit abort any reception in progress.
//   i_sys_clk, i_sys_rst : clock, synchronous active-low reset
//   i_scl, i_sda         : synchronized bus lines
//   rx_if                : request/result bundle (slave side)
module ddr_rx_target
  import ddr_rx_pkg::*;
(
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_scl,
  input  logic             i_sda,
  ddr_rx_target_if.slave   rx_if
);

  rx_state_e   state_q;
  logic [4:0]  mode_q;
  logic [4:0]  cnt_q;
  logic [15:0] shift_q;
  logic [15:0] hist_q;
  logic        scl_q;
  logic        done_q;
  logic [1:0]  preamble_q;
  logic        rnw_q;
  logic [7:0]  ccc_q;
  logic [7:0]  byte_q;
  logic [15:0] word_q;
  logic        err_q;

  logic [4:0]  cnt_d;
  logic [15:0] shift_d;
  logic [15:0] hist_d;
  logic        scl_edge;
  logic        abort;
  logic        restart_pulse;
  logic        exit_pulse;

  hdr_pattern_detector u_pattern (
    .i_sys_clk      (i_sys_clk),
    .i_sys_rst      (i_sys_rst),
    .i_scl          (i_scl),
    .i_sda          (i_sda),
    .o_abort        (abort),
    .o_restart_done (restart_pulse),
    .o_exit_done    (exit_pulse)
  );

  // shift_d already holds the bit being sampled, so the output fields can be
  // loaded on the final edge and be valid together with the done pulse.
  always_comb begin
    scl_edge = i_scl ^ scl_q;
    cnt_d    = cnt_q + 5'd1;
    shift_d  = {shift_q[14:0], i_sda};
    hist_d   = {hist_q[14:0], i_sda};
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      hist_q     <= '0;
      scl_q      <= 1'b0;
      done_q     <= 1'b0;
      preamble_q <= '0;
      rnw_q      <= 1'b0;
      ccc_q      <= '0;
      byte_q     <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      // Tracked in every state so an edge in the start cycle is consumed.
      scl_q  <= i_scl;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_if.i_rx_en) begin
            mode_q <= rx_if.i_rx_mode;
            cnt_q  <= '0;
            if (mode_legal(rx_if.i_rx_mode)) begin
              err_q   <= 1'b0;
              state_q <= ST_RECV;
            end else begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_RECV: begin
          // Abort has priority over a coincident final-bit edge.
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (scl_edge) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (mode_has_parity(mode_q)) hist_q <= hist_d;
            if (cnt_d == mode_len(mode_q)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
              case (mode_q)
                MODE_PREAMBLE: begin
                  preamble_q <= shift_d[1:0];
                  hist_q     <= '0;
                end
                MODE_CMD_WORD: begin
                  rnw_q <= shift_d[15];
                  ccc_q <= shift_d[7:0];
                end
                MODE_DESER_BYTE:   byte_q <= shift_d[7:0];
                MODE_CHECK_PARITY: err_q  <= (shift_d[1:0] != ddr_parity(hist_q));
                MODE_DATA_WORD:    word_q <= shift_d;
                default:           err_q  <= 1'b1;
              endcase
            end
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_if.o_rx_mode_done = done_q;
  assign rx_if.o_preamble     = preamble_q;
  assign rx_if.o_rnw          = rnw_q;
  assign rx_if.o_ccc_value    = ccc_q;
  assign rx_if.o_rx_byte      = byte_q;
  assign rx_if.o_rx_word      = word_q;
  assign rx_if.o_rx_error     = err_q;
  assign rx_if.o_restart_done = restart_pulse;
  assign rx_if.o_exit_done    = exit_pulse;
  assign rx_if.o_busy         = (state_q == ST_RECV);

endmodule

// File: tb/tb_ddr_rx_target.sv
// tb_ddr_rx_target: directed self-checking bench for ddr_rx_target.
module tb_ddr_rx_target;

  logic clk;
  logic rst_n;
  logic scl;
  logic sda;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int restart_seen = 0;
  int exit_seen = 0;

  ddr_rx_target_if rx_if ();

  ddr_rx_target dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .i_scl     (scl),
    .i_sda     (sda),
    .rx_if     (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the rising edge (outputs are stable there).
  always @(posedge clk) begin
    if (rx_if.o_rx_mode_done) done_seen++;
    if (rx_if.o_restart_done) restart_seen++;
    if (rx_if.o_exit_done) exit_seen++;
  end

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] all_outputs();
    return {rx_if.o_preamble, rx_if.o_rnw, rx_if.o_ccc_value, rx_if.o_rx_byte,
            rx_if.o_rx_word, rx_if.o_rx_error, rx_if.o_rx_mode_done,
            rx_if.o_restart_done, rx_if.o_exit_done, rx_if.o_busy};
  endfunction

  task automatic start_rx(input logic [4:0] m);
    @(negedge clk);
    rx_if.i_rx_en   = 1'b1;
    rx_if.i_rx_mode = m;
    @(negedge clk);
    rx_if.i_rx_en   = 1'b0;
  endtask

  // Set SDA, then toggle SCL; returns on the negedge after the sampling edge.
  task automatic drive_bit(input logic b);
    @(negedge clk);
    sda = b;
    @(negedge clk);
    scl = ~scl;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic set_sda(input logic b);
    @(negedge clk);
    sda = b;
  endtask

  int d0;
  int r0;
  int e0;

  initial begin
    rst_n = 1'b0;
    scl = 1'b0;
    sda = 1'b0;
    rx_if.i_rx_en = 1'b0;
    rx_if.i_rx_mode = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 48'(all_outputs()), 48'h0);
    rst_n = 1'b1;

    // PREAMBLE 0,1
    start_rx(5'd0);
    check_eq("pre_busy", 48'(rx_if.o_busy), 48'h1);
    drive_bit(1'b0);
    check_eq("pre_no_early_done", 48'(rx_if.o_rx_mode_done), 48'h0);
    drive_bit(1'b1);
    check_eq("pre_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("pre_value", 48'(rx_if.o_preamble), 48'h1);
    @(negedge clk);
    check_eq("pre_done_drop", 48'(rx_if.o_rx_mode_done), 48'h0);
    check_eq("pre_idle", 48'(rx_if.o_busy), 48'h0);

    // CMD_WORD 8009; history 8009 gives expected parity 2'b00
    start_rx(5'd1);
    send_bits(16'h8009, 16);
    check_eq("cmd_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("cmd_rnw", 48'(rx_if.o_rnw), 48'h1);
    check_eq("cmd_ccc", 48'(rx_if.o_ccc_value), 48'h09);
    start_rx(5'd3);
    send_bits(16'b00, 2);
    check_eq("par_ok_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("par_ok_err", 48'(rx_if.o_rx_error), 48'h0);
    start_rx(5'd3);
    send_bits(16'b01, 2);
    check_eq("par_bad_err", 48'(rx_if.o_rx_error), 48'h1);
    repeat (2) @(negedge clk);
    check_eq("par_err_held", 48'(rx_if.o_rx_error), 48'h1);
    start_rx(5'd3);
    check_eq("par_err_cleared", 48'(rx_if.o_rx_error), 48'h0);
    send_bits(16'b10, 2);
    check_eq("par_bad2_err", 48'(rx_if.o_rx_error), 48'h1);

    // PREAMBLE clears history; bytes A5,3C -> expected parity 2'b01
    start_rx(5'd0);
    send_bits(16'b11, 2);
    check_eq("pre2_value", 48'(rx_if.o_preamble), 48'h3);
    start_rx(5'd2);
    send_bits(16'hA5, 8);
    check_eq("byte1_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("byte1_value", 48'(rx_if.o_rx_byte), 48'hA5);
    start_rx(5'd2);
    send_bits(16'h3C, 8);
    check_eq("byte2_value", 48'(rx_if.o_rx_byte), 48'h3C);
    check_eq("pre_held", 48'(rx_if.o_preamble), 48'h3);
    start_rx(5'd3);
    send_bits(16'b01, 2);
    check_eq("par_a53c_err", 48'(rx_if.o_rx_error), 48'h0);

    // DATA_WORD 1234 with a single done pulse
    repeat (2) @(negedge clk);
    d0 = done_seen;
    start_rx(5'd4);
    send_bits(16'h1234, 16);
    check_eq("word_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("word_value", 48'(rx_if.o_rx_word), 48'h1234);
    repeat (3) @(negedge clk);
    check_eq("word_one_pulse", 48'(done_seen - d0), 48'h1);

    // Restart mid CMD_WORD: SCL high before start so 7 toggles leave it low
    @(negedge clk);
    scl = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_seen;
    r0 = restart_seen;
    start_rx(5'd1);
    send_bits(16'h0055, 7);
    check_eq("rs_busy_mid", 48'(rx_if.o_busy), 48'h1);
    set_sda(1'b1);
    set_sda(1'b0);
    set_sda(1'b1);
    set_sda(1'b0);
    repeat (2) @(negedge clk);
    check_eq("rs_abort_busy", 48'(rx_if.o_busy), 48'h0);
    scl = 1'b1;
    @(negedge clk);
    check_eq("rs_pulse", 48'(rx_if.o_restart_done), 48'h1);
    check_eq("rs_no_done", 48'(rx_if.o_rx_mode_done), 48'h0);
    @(negedge clk);
    check_eq("rs_pulse_drop", 48'(rx_if.o_restart_done), 48'h0);
    check_eq("rs_fields_kept", 48'({rx_if.o_rnw, rx_if.o_ccc_value}), 48'h109);
    repeat (2) @(negedge clk);
    check_eq("rs_count", 48'(restart_seen - r0), 48'h1);
    check_eq("rs_done_count", 48'(done_seen - d0), 48'h0);

    // Exit mid CMD_WORD: 4 SDA falls with SCL low
    d0 = done_seen;
    r0 = restart_seen;
    e0 = exit_seen;
    start_rx(5'd1);
    send_bits(16'h002A, 7);
    set_sda(1'b1);
    set_sda(1'b0);
    set_sda(1'b1);
    set_sda(1'b0);
    set_sda(1'b1);
    set_sda(1'b0);
    set_sda(1'b1);
    set_sda(1'b0);
    @(negedge clk);
    check_eq("ex_pulse", 48'(rx_if.o_exit_done), 48'h1);
    check_eq("ex_busy", 48'(rx_if.o_busy), 48'h0);
    @(negedge clk);
    check_eq("ex_pulse_drop", 48'(rx_if.o_exit_done), 48'h0);
    scl = 1'b1;
    @(negedge clk);
    check_eq("ex_no_restart", 48'(rx_if.o_restart_done), 48'h0);
    repeat (2) @(negedge clk);
    check_eq("ex_count", 48'(exit_seen - e0), 48'h1);
    check_eq("ex_rs_count", 48'(restart_seen - r0), 48'h0);
    check_eq("ex_done_count", 48'(done_seen - d0), 48'h0);

    // Illegal mode
    start_rx(5'd7);
    check_eq("ill_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("ill_err", 48'(rx_if.o_rx_error), 48'h1);
    check_eq("ill_busy", 48'(rx_if.o_busy), 48'h0);
    @(negedge clk);
    check_eq("ill_done_drop", 48'(rx_if.o_rx_mode_done), 48'h0);

    // i_rx_en during RECV is ignored; byte C3 still takes exactly 8 bits
    start_rx(5'd2);
    send_bits(16'b110, 3);
    @(negedge clk);
    rx_if.i_rx_en   = 1'b1;
    rx_if.i_rx_mode = 5'd4;
    @(negedge clk);
    rx_if.i_rx_en   = 1'b0;
    send_bits(16'b0001, 4);
    check_eq("en_ign_no_early", 48'(rx_if.o_rx_mode_done), 48'h0);
    drive_bit(1'b1);
    check_eq("en_ign_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("en_ign_byte", 48'(rx_if.o_rx_byte), 48'hC3);
    check_eq("en_ign_err", 48'(rx_if.o_rx_error), 48'h0);

    // Reset mid DATA_WORD
    start_rx(5'd4);
    send_bits(16'h00AB, 8);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_outputs", 48'(all_outputs()), 48'h0);
    rst_n = 1'b1;
    start_rx(5'd4);
    send_bits(16'hBEEF, 16);
    check_eq("rst_after_done", 48'(rx_if.o_rx_mode_done), 48'h1);
    check_eq("rst_after_word", 48'(rx_if.o_rx_word), 48'hBEEF);
    check_eq("rst_after_pre", 48'(rx_if.o_preamble), 48'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
